wb_burst_master: RTL

//  Wishbone B3 master issuing single or incrementing-burst word transfers to a

---
 rtl/wb_burst_master_if.sv | 40 ++++
 rtl/wb_burst_master.sv | 132 +++++++++++++
 2 files changed

// File: rtl/wb_burst_master_if.sv
// Bus bundle for wb_burst_master: local command/data stream side plus Wishbone B3 master side.
// The master modport is the DUT view; the slave modport is the environment view.
interface wb_burst_master_if #(
  parameter int ADR_WIDTH = 24,
  parameter int LEN_WIDTH = 8
);
  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic                 cmd_we_i;
  logic [ADR_WIDTH-3:0] cmd_adr_i;
  logic [LEN_WIDTH-1:0] cmd_len_i;
  logic [31:0]          wdat_i;
  logic                 wdat_rd_o;
  logic [31:0]          rdat_o;
  logic                 rdat_valid_o;
  logic                 done_o;
  logic                 err_o;
  logic [ADR_WIDTH-3:0] adr_o;
  logic [31:0]          dat_o;
  logic [31:0]          dat_i;
  logic                 we_o;
  logic                 cyc_o;
  logic                 stb_o;
  logic [3:0]           sel_o;
  logic [2:0]           cti_o;
  logic [1:0]           bte_o;
  logic                 ack_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_len_i, wdat_i, dat_i, ack_i,
    output cmd_ready_o, wdat_rd_o, rdat_o, rdat_valid_o, done_o, err_o,
           adr_o, dat_o, we_o, cyc_o, stb_o, sel_o, cti_o, bte_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_len_i, wdat_i, dat_i, ack_i,
    input  cmd_ready_o, wdat_rd_o, rdat_o, rdat_valid_o, done_o, err_o,
           adr_o, dat_o, we_o, cyc_o, stb_o, sel_o, cti_o, bte_o
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 master: single or incrementing-burst word transfers with a per-ack watchdog.
// Write data streams from an FWFT FIFO head; read data leaves as a one-cycle-late valid stream.
module wb_burst_master #(
  parameter int ADR_WIDTH = 24,
  parameter int LEN_WIDTH = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  wb_burst_master_if.master bus
);
  localparam int AW  = ADR_WIDTH - 2;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic {IDLE, BUS} state_t;

  state_t               state, state_n;
  logic                 ready_q;
  logic                 we_q, we_n;
  logic [AW-1:0]        adr_q, adr_n;
  logic [LEN_WIDTH-1:0] rem_q, rem_n;
  logic [2:0]           cti_q, cti_n;
  logic [WDW-1:0]       wdog_q, wdog_n;
  logic                 cyc_q, cyc_n;
  logic                 done_q, done_n;
  logic                 err_q, err_n;
  logic [31:0]          rdat_q;
  logic                 rvalid_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      rem_q    <= '0;
      cti_q    <= CTI_CLASSIC;
      wdog_q   <= '0;
      cyc_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdat_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state    <= state_n;
      ready_q  <= 1'b1;
      we_q     <= we_n;
      adr_q    <= adr_n;
      rem_q    <= rem_n;
      cti_q    <= cti_n;
      wdog_q   <= wdog_n;
      cyc_q    <= cyc_n;
      done_q   <= done_n;
      err_q    <= err_n;
      rdat_q   <= bus.dat_i;
      rvalid_q <= bus.ack_i & ~we_q & cyc_q;
    end
  end

  always_comb begin
    state_n = state;
    we_n    = we_q;
    adr_n   = adr_q;
    rem_n   = rem_q;
    cti_n   = cti_q;
    wdog_n  = wdog_q;
    cyc_n   = cyc_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid_i && ready_q) begin
          if (bus.cmd_len_i == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = BUS;
            cyc_n   = 1'b1;
            we_n    = bus.cmd_we_i;
            adr_n   = bus.cmd_adr_i;
            rem_n   = bus.cmd_len_i;
            cti_n   = (bus.cmd_len_i == LEN_WIDTH'(1)) ? CTI_CLASSIC : CTI_INCR;
            wdog_n  = '0;
          end
        end
      end
      BUS: begin
        if (bus.ack_i) begin
          adr_n  = adr_q + 1'b1;
          rem_n  = rem_q - 1'b1;
          wdog_n = '0;
          if (rem_q == LEN_WIDTH'(1)) begin
            state_n = IDLE;
            cyc_n   = 1'b0;
            cti_n   = CTI_CLASSIC;
            done_n  = 1'b1;
          end else if (rem_q == LEN_WIDTH'(2)) begin
            // Only bursts ever see two remaining, so no separate burst flag is kept.
            cti_n = CTI_END;
          end
        end else if (wdog_q == WD_LAST) begin
          state_n = IDLE;
          cyc_n   = 1'b0;
          cti_n   = CTI_CLASSIC;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end else begin
          wdog_n = wdog_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.cmd_ready_o  = ready_q & (state == IDLE);
  assign bus.adr_o        = adr_q;
  assign bus.dat_o        = bus.wdat_i;
  assign bus.we_o         = we_q;
  assign bus.cyc_o        = cyc_q;
  assign bus.stb_o        = cyc_q;
  assign bus.sel_o        = 4'b1111;
  assign bus.cti_o        = cti_q;
  assign bus.bte_o        = 2'b00;
  assign bus.wdat_rd_o    = bus.ack_i & we_q & cyc_q;
  assign bus.rdat_o       = rdat_q;
  assign bus.rdat_valid_o = rvalid_q;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;
endmodule
